// File: rtl/inst_decode_queue.sv
// Instruction queue between fetch and execute. The head entry is decoded
// combinationally into MIPS-style R/I/J fields, the extended immediate and the jump target.
module inst_decode_queue #(
    parameter int DEPTH     = 4,
    parameter int IMM_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [5:0]               op,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               sa,
    output logic [5:0]               funct,
    output logic [IMM_WIDTH-1:0]     imm_ext,
    output logic [25:0]              address,
    output logic [31:0]              jump_target,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head_inst;
    logic [31:0]   w_head_pc;
    logic [15:0]   w_imm16;
    logic          w_zext;
    logic [3:0]    w_pc4_hi;

    // Handshake flags come only from the registered count, never from in_valid/out_ready.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wr_ptr] <= in_inst;
            r_pc[r_wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Masking the head to zero makes every decoded field zero when empty.
    assign w_head_inst = out_valid ? r_inst[r_rd_ptr] : '0;
    assign w_head_pc   = out_valid ? r_pc[r_rd_ptr]   : '0;

    assign out_pc  = w_head_pc;
    assign op      = w_head_inst[31:26];
    assign rs      = w_head_inst[25:21];
    assign rt      = w_head_inst[20:16];
    assign rd      = w_head_inst[15:11];
    assign sa      = w_head_inst[10:6];
    assign funct   = w_head_inst[5:0];
    assign address = w_head_inst[25:0];
    assign w_imm16 = w_head_inst[15:0];

    // andi/ori/xori/lui (0x0C..0x0F) zero-extend; everything else sign-extends.
    assign w_zext  = (op[5:2] == 4'b0011);
    assign imm_ext = w_zext ? IMM_WIDTH'(w_imm16) : IMM_WIDTH'($signed(w_imm16));

    // Upper nibble of pc+4: carry into bit 28 only when pc[27:2] is all ones.
    assign w_pc4_hi    = w_head_pc[31:28] + {3'b000, &w_head_pc[27:2]};
    assign jump_target = {w_pc4_hi, address, 2'b00};

endmodule

// File: tb/tb_inst_decode_queue.sv
// Randomized scoreboard bench for inst_decode_queue: a queue-based reference
// model is updated at each clock edge and a negedge monitor compares the head.
module tb_inst_decode_queue;
    localparam int DEPTH     = 4;
    localparam int IMM_WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [31:0]            in_inst = '0;
    logic [31:0]            in_pc = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [31:0]            out_pc;
    logic [5:0]             op;
    logic [4:0]             rs, rt, rd, sa;
    logic [5:0]             funct;
    logic [IMM_WIDTH-1:0]   imm_ext;
    logic [25:0]            address;
    logic [31:0]            jump_target;
    logic [$clog2(DEPTH):0] count;

    inst_decode_queue #(.DEPTH(DEPTH), .IMM_WIDTH(IMM_WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
        .imm_ext(imm_ext), .address(address), .jump_target(jump_target),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;
    bit   push_happened = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue follows the handshake rules at every edge.
    always @(posedge clk) begin
        int  sz;
        bit  do_pop;
        bit  do_push;
        sz = sb.size();
        push_happened = 1'b0;
        if (reset || flush) begin
            sb.delete();
        end else begin
            do_pop  = (sz > 0) && out_ready;
            do_push = in_valid && (sz < DEPTH);
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back('{inst: in_inst, pc: in_pc});
                push_happened = 1'b1;
            end
        end
    end

    // Monitor: compares occupancy, handshake flags and the decoded head.
    always @(negedge clk) begin
        ent_t        e;
        logic [31:0] ei;
        logic [31:0] ej;
        logic [5:0]  eop;
        if (chk_en) begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
            if (sb.size() > 0) e = sb[0];
            else               e = '0;
            eop = e.inst[31:26];
            if (eop inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) ei = {16'h0000, e.inst[15:0]};
            else                                          ei = {{16{e.inst[15]}}, e.inst[15:0]};
            ej = ((e.pc + 32'd4) & 32'hF000_0000) | {4'h0, e.inst[25:0], 2'b00};
            chk("out_pc", out_pc, e.pc);
            chk("op", 32'(op), 32'(eop));
            chk("rs", 32'(rs), 32'(e.inst[25:21]));
            chk("rt", 32'(rt), 32'(e.inst[20:16]));
            chk("rd", 32'(rd), 32'(e.inst[15:11]));
            chk("sa", 32'(sa), 32'(e.inst[10:6]));
            chk("funct", 32'(funct), 32'(e.inst[5:0]));
            chk("imm_ext", 32'(imm_ext), ei);
            chk("address", 32'(address), 32'(e.inst[25:0]));
            chk("jump_target", jump_target, ej);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v[31:26] = 6'($urandom_range(12, 15));
        return v;
    endfunction

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 3) == 0) return {4'($urandom_range(0, 15)), 26'h3FF_FFFF, 2'b00};
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    task automatic clear_with(input bit use_reset);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = rnd_inst(); in_pc = rnd_pc(); out_ready = 1'b0;
            tick();
        end
        chk("pre_clear_count", 32'(count), 32'd3);
        in_valid = 1'b1; in_inst = 32'h1234_5678; out_ready = 1'b1;
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_in_ready", 32'(in_ready), 32'd1);
        chk("clear_op", 32'(op), 32'd0);
        chk("clear_out_pc", out_pc, 32'd0);
        chk("clear_jump_target", jump_target, 32'd0);
        chk("clear_imm_ext", 32'(imm_ext), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        push1(32'h3C01_ABCD, 32'h0040_0000);
        chk("lui_valid", 32'(out_valid), 32'd1);
        chk("lui_op", 32'(op), 32'h0F);
        chk("lui_rt", 32'(rt), 32'd1);
        chk("lui_imm", 32'(imm_ext), 32'h0000_ABCD);
        chk("lui_count", 32'(count), 32'd1);
        tick(); tick();
        chk("lui_hold_op", 32'(op), 32'h0F);
        chk("lui_hold_pc", out_pc, 32'h0040_0000);
        pop1();

        push1(32'h2022_FFFC, 32'h0040_0004);
        chk("addi_imm", 32'(imm_ext), 32'hFFFF_FFFC);
        chk("addi_rs", 32'(rs), 32'd1);
        chk("addi_rt", 32'(rt), 32'd2);
        pop1();
        push1(32'h00A6_3820, 32'h0040_0008);
        chk("add_rs", 32'(rs), 32'd5);
        chk("add_rt", 32'(rt), 32'd6);
        chk("add_rd", 32'(rd), 32'd7);
        chk("add_sa", 32'(sa), 32'd0);
        chk("add_funct", 32'(funct), 32'h20);
        pop1();
        push1(32'h0810_0004, 32'h0040_0010);
        chk("j_address", 32'(address), 32'h010_0004);
        chk("j_target", jump_target, 32'h0040_0010);
        pop1();

        // Three fill/drain rounds with a fifth push attempted while full.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                in_valid = 1'b1; in_inst = rnd_inst(); in_pc = rnd_pc(); out_ready = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            chk("full_count", 32'(count), 32'(DEPTH));
            chk("full_in_ready", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
            for (int i = 0; i < DEPTH; i++) tick();
            out_ready = 1'b0;
            chk("drained_count", 32'(count), 32'd0);
        end

        // Steady stream: one in, one out every cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_inst = rnd_inst(); in_pc = rnd_pc();
            tick();
            chk("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        clear_with(1'b0);
        clear_with(1'b1);

        // Random traffic; the source holds its word until it is accepted.
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || push_happened) begin
                in_inst = rnd_inst(); in_pc = rnd_pc();
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        chk("final_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
